// File: rtl/scaler_pkg.sv
// scaler_pkg: shared state encoding and FIFO word layout for the scaler pixel feeder
package scaler_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CHANNELS = 3;
    localparam int PIX_W = DEF_DATA_WIDTH * DEF_CHANNELS;
    // Tag bit offsets above the pixel field: SOF at PIX_W, EOL at PIX_W+1
    localparam int SOF_OFS = 0;
    localparam int EOL_OFS = 1;
    typedef enum logic [1:0] {
        FEED_IDLE,
        FEED_DISCARD,
        FEED_ACTIVE,
        FEED_DRAIN
    } feed_state_e;
endpackage

// File: rtl/scaler_pixel_feeder_if.sv
// scaler_pixel_feeder_if: upstream source and scaler-side pixel stream of the feeder
interface scaler_pixel_feeder_if import scaler_pkg::*; #(
    parameter int PW = PIX_W
) ();
    logic [PW-1:0] srcData;
    logic          srcValid;
    logic          srcReady;
    logic [PW-1:0] dIn;
    logic          dInValid;
    logic          dInSof;
    logic          dInEol;
    logic          din_Enable;
    modport master (
        input  srcData, srcValid, din_Enable,
        output srcReady, dIn, dInValid, dInSof, dInEol
    );
    modport slave (
        output srcData, srcValid, din_Enable,
        input  srcReady, dIn, dInValid, dInSof, dInEol
    );
endinterface

// File: rtl/scaler_pixel_fifo.sv
// scaler_pixel_fifo: synchronous FIFO with wrap-bit pointers; full/empty come from registered pointers
module scaler_pixel_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_q, rd_q;
    logic do_push, do_pop;
    assign full = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
    assign empty = wr_q == rd_q;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = mem[rd_q[AW-1:0]];
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q[AW-1:0]] <= din;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
        end
    end
endmodule

// File: rtl/scaler_pixel_feeder.sv
// scaler_pixel_feeder: discards header words, tags SOF/EOL and buffers pixels for video_scaler.
// Optional CHANNEL_REVERSE_EN reverses channel order of every stored pixel.
module scaler_pixel_feeder import scaler_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int FIFO_DEPTH = 8,
    parameter int X_RES_WIDTH = 11,
    parameter int Y_RES_WIDTH = 11,
    parameter int DISCARD_CNT_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         frameGo,
    input  logic [DISCARD_CNT_WIDTH-1:0] inputDiscardCnt,
    input  logic [X_RES_WIDTH-1:0]       inputXRes,
    input  logic [Y_RES_WIDTH-1:0]       inputYRes,
    scaler_pixel_feeder_if.master        px,
    output logic                         start,
    output logic                         frameDone,
    output logic                         busy
);
    localparam int PW = DATA_WIDTH * CHANNELS;
    feed_state_e state_q, state_d;
    logic [DISCARD_CNT_WIDTH-1:0] disc_q;
    logic [X_RES_WIDTH-1:0] xres_q, x_q;
    logic [Y_RES_WIDTH-1:0] yres_q, y_q;
    logic [PW-1:0] pix;
    logic [PW+1:0] fifo_dout;
    logic full, empty, src_hs, push, pop, arm, sof, eol, last, drained;
    assign px.srcReady = state_q == FEED_DISCARD || (state_q == FEED_ACTIVE && !full);
    assign src_hs = px.srcValid && px.srcReady;
    assign push = src_hs && state_q == FEED_ACTIVE;
    assign pop = !empty && (!px.dInValid || px.din_Enable);
    assign arm = state_q == FEED_IDLE && frameGo;
    assign sof = x_q == '0 && y_q == '0;
    assign eol = x_q == xres_q;
    assign last = eol && y_q == yres_q;
    assign drained = empty && !px.dInValid;
    assign busy = state_q != FEED_IDLE;
    always_comb begin
        pix = px.srcData;
`ifdef CHANNEL_REVERSE_EN
        for (int c = 0; c < CHANNELS; c++)
            pix[c*DATA_WIDTH +: DATA_WIDTH] = px.srcData[(CHANNELS-1-c)*DATA_WIDTH +: DATA_WIDTH];
`endif
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            FEED_IDLE:    if (frameGo) state_d = inputDiscardCnt != '0 ? FEED_DISCARD : FEED_ACTIVE;
            FEED_DISCARD: if (src_hs && disc_q == DISCARD_CNT_WIDTH'(1)) state_d = FEED_ACTIVE;
            FEED_ACTIVE:  if (push && last) state_d = FEED_DRAIN;
            FEED_DRAIN:   if (drained) state_d = FEED_IDLE;
        endcase
    end
    scaler_pixel_fifo #(.WIDTH(PW + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .pop(pop),
        .din({eol, sof, pix}),
        .dout(fifo_dout),
        .full(full),
        .empty(empty)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FEED_IDLE;
            disc_q <= '0;
            xres_q <= '0;
            yres_q <= '0;
            x_q <= '0;
            y_q <= '0;
            start <= 1'b0;
            frameDone <= 1'b0;
        end else begin
            state_q <= state_d;
            start <= push && sof;
            frameDone <= state_q == FEED_DRAIN && drained;
            if (arm) begin
                disc_q <= inputDiscardCnt;
                xres_q <= inputXRes;
                yres_q <= inputYRes;
                x_q <= '0;
                y_q <= '0;
            end else begin
                if (state_q == FEED_DISCARD && src_hs) disc_q <= disc_q - 1'b1;
                if (push) x_q <= eol ? '0 : x_q + 1'b1;
                if (push && eol) y_q <= y_q + 1'b1;
            end
        end
    end
    // Output stage refills whenever it is empty or its pixel is being taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px.dIn <= '0;
            px.dInValid <= 1'b0;
            px.dInSof <= 1'b0;
            px.dInEol <= 1'b0;
        end else if (pop) begin
            px.dIn <= fifo_dout[PW-1:0];
            px.dInValid <= 1'b1;
            px.dInSof <= fifo_dout[PW+SOF_OFS];
            px.dInEol <= fifo_dout[PW+EOL_OFS];
        end else if (px.din_Enable) begin
            px.dInValid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_scaler_pixel_feeder.sv
// tb_scaler_pixel_feeder: directed frames with hand-computed pixel order, tags and pulses
module tb_scaler_pixel_feeder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frameGo = 1'b0;
    logic [7:0] disc = '0;
    logic [10:0] xres = '0;
    logic [10:0] yres = '0;
    logic start, frameDone, busy;
    logic [25:0] got[$];
    int n_start, n_done, done_at, n_acc;
    int total = 0;
    int bad = 0;
    scaler_pixel_feeder_if ifc ();
    scaler_pixel_feeder dut (
        .clk(clk),
        .rst_n(rst_n),
        .frameGo(frameGo),
        .inputDiscardCnt(disc),
        .inputXRes(xres),
        .inputYRes(yres),
        .px(ifc),
        .start(start),
        .frameDone(frameDone),
        .busy(busy)
    );
    always #5 clk = ~clk;
    function automatic logic [23:0] model_pix(logic [23:0] w);
`ifdef CHANNEL_REVERSE_EN
        return {w[7:0], w[15:8], w[23:16]};
`else
        return w;
`endif
    endfunction
    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask
    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic clear();
        got.delete();
        n_start = 0;
        n_done = 0;
        done_at = 0;
        n_acc = 0;
    endtask
    task automatic arm(logic [7:0] d, logic [10:0] x, logic [10:0] y);
        disc = d;
        xres = x;
        yres = y;
        frameGo = 1'b1;
        tick(1);
        frameGo = 1'b0;
    endtask
    task automatic wait_done(string tag);
        for (int i = 0; i < 500 && n_done == 0; i++) tick(1);
        check(tag, n_done != 0, 1);
        tick(3);
    endtask
    task automatic check_frame(string tag, int n, logic [23:0] base, int xr);
        check({tag, " count"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++)
            check({tag, " pix"}, got[i], {i % (xr + 1) == xr, i == 0, model_pix(base + 24'(i))});
        check({tag, " start"}, n_start, 1);
        check({tag, " done"}, n_done, 1);
        check({tag, " done_at"}, done_at, n);
    endtask
    initial forever begin
        @(negedge clk);
        if (ifc.dInValid && ifc.din_Enable) got.push_back({ifc.dInEol, ifc.dInSof, ifc.dIn});
        if (start) n_start++;
        if (frameDone) begin
            n_done++;
            done_at = got.size();
        end
    end
    initial forever begin
        logic hs;
        @(negedge clk);
        hs = ifc.srcValid && ifc.srcReady;
        @(posedge clk);
        #1;
        if (hs) begin
            ifc.srcData = ifc.srcData + 1'b1;
            n_acc++;
        end
    end
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
    initial begin
        ifc.srcValid = 1'b1;
        ifc.din_Enable = 1'b1;
        ifc.srcData = 24'h1;
        clear();
        tick(2);
        check("rst flags", {ifc.srcReady, ifc.dInValid, ifc.dInSof, ifc.dInEol, start, frameDone, busy}, 0);
        check("rst dIn", ifc.dIn, 0);
        rst_n = 1'b1;
        tick(1);
        // basic frame with two discarded header words
        clear();
        ifc.srcData = 24'h1;
        arm(8'd2, 11'd3, 11'd1);
        wait_done("t1 wait");
        check_frame("t1", 8, 24'h3, 3);
        // zero discard goes straight to ACTIVE
        clear();
        ifc.srcData = 24'h1;
        arm(8'd0, 11'd3, 11'd1);
        check("t2 busy", busy, 1);
        wait_done("t2 wait");
        check_frame("t2", 8, 24'h1, 3);
        // back-pressure: FIFO plus output register fill, then the frame finishes intact
        clear();
        ifc.srcData = 24'h100;
        arm(8'd0, 11'd15, 11'd1);
        tick(5);
        ifc.din_Enable = 1'b0;
        tick(20);
        check("t3 held", ifc.dIn, model_pix(24'h100 + 24'(got.size())));
        check("t3 valid", ifc.dInValid, 1);
        check("t3 ready", ifc.srcReady, 0);
        check("t3 occupancy", n_acc - got.size(), 9);
        ifc.din_Enable = 1'b1;
        wait_done("t3 wait");
        check_frame("t3", 32, 24'h100, 15);
        // asynchronous reset mid-frame, then a clean frame
        clear();
        ifc.srcData = 24'h200;
        arm(8'd0, 11'd3, 11'd1);
        tick(3);
        rst_n = 1'b0;
        #2;
        check("t4 rst flags", {ifc.srcReady, ifc.dInValid, ifc.dInSof, ifc.dInEol, start, frameDone, busy}, 0);
        check("t4 rst dIn", ifc.dIn, 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        clear();
        ifc.srcData = 24'h20;
        arm(8'd0, 11'd3, 11'd1);
        wait_done("t4 wait");
        check_frame("t4", 8, 24'h20, 3);
        // frameGo during ACTIVE with a different resolution is ignored
        clear();
        ifc.srcData = 24'h112233;
        arm(8'd0, 11'd3, 11'd1);
        tick(3);
        arm(8'd5, 11'd0, 11'd0);
        wait_done("t5 wait");
`ifdef CHANNEL_REVERSE_EN
        check("t5 first", got.size() > 0 ? got[0][23:0] : 24'h0, 24'h332211);
`else
        check("t5 first", got.size() > 0 ? got[0][23:0] : 24'h0, 24'h112233);
`endif
        check_frame("t5", 8, 24'h112233, 3);
        // single-pixel frame: SOF and EOL together
        clear();
        ifc.srcData = 24'h55;
        arm(8'd0, 11'd0, 11'd0);
        wait_done("t6 wait");
        check_frame("t6", 1, 24'h55, 0);
        // one-pixel lines: every pixel carries EOL
        clear();
        ifc.srcData = 24'h60;
        arm(8'd1, 11'd0, 11'd2);
        wait_done("t7 wait");
        check_frame("t7", 3, 24'h61, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/scaler_pixel_feeder.md
Name: scaler_pixel_feeder

Overview:
Synthesizable front-end that feeds a raw pixel stream into video_scaler's dIn/dInValid/din_Enable port. It replaces the behavioural file-reader stimulus with hardware.
- Skips a programmable number of leading words (header/clip discard).
- Counts x/y against the input resolution and tags start-of-frame (SOF) and end-of-line (EOL).
- Buffers pixels in a parametrised FIFO so scaler back-pressure never drops data.
- Generalised over channel count, channel width and buffer depth; adds a frame-level state machine and done reporting.

Parameters:
DATA_WIDTH, 8, bits per colour channel
CHANNELS, 3, colour channels per pixel
FIFO_DEPTH, 8, pixel FIFO entries; power of two, >=2
X_RES_WIDTH, 11, width of inputXRes and of the x counter
Y_RES_WIDTH, 11, width of inputYRes and of the y counter
DISCARD_CNT_WIDTH, 8, width of inputDiscardCnt

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
frameGo  in  1  one-cycle pulse; arms one frame
inputDiscardCnt  in  DISCARD_CNT_WIDTH  leading words to drop
inputXRes  in  X_RES_WIDTH  pixels per line minus 1
inputYRes  in  Y_RES_WIDTH  lines per frame minus 1
srcData  in  DATA_WIDTH*CHANNELS  upstream pixel, channel 0 in LSBs
srcValid  in  1  upstream word valid
srcReady  out  1  feeder accepts srcData this cycle
dIn  out  DATA_WIDTH*CHANNELS  pixel to scaler
dInValid  out  1  dIn valid
dInSof  out  1  dIn is pixel (0,0)
dInEol  out  1  dIn is last pixel of a line
din_Enable  in  1  scaler can take dIn this cycle
start  out  1  one-cycle pulse on first accepted active pixel
frameDone  out  1  one-cycle pulse when the frame has fully drained
busy  out  1  state != IDLE

Behaviour:
- Reset values: srcReady, dIn, dInValid, dInSof, dInEol, start, frameDone and busy are all 0. State is IDLE. FIFO is empty and all counters are 0.
- Reset asserted mid-frame clears everything immediately; partial FIFO contents are lost.
- States:
  - IDLE:
    - srcReady=0.
    - On frameGo, latch inputDiscardCnt, inputXRes and inputYRes into shadow registers.
    - Next state is DISCARD if the latched count is non-zero, else ACTIVE.
    - frameGo outside IDLE is ignored.
  - DISCARD:
    - srcReady=1.
    - Each handshake (srcValid&&srcReady) decrements the count; the word is not stored.
    - The handshake that takes the count to 0 moves the state to ACTIVE.
  - ACTIVE:
    - srcReady = !fifoFull, where fifoFull is taken from the registered occupancy. A push is blocked when the FIFO is full, even if a pop happens in the same cycle.
    - Each handshake writes {EOL, SOF, pixel} into the FIFO.
    - x increments per pixel and wraps to 0 after inputXRes; y increments on each wrap.
    - SOF = (x==0 && y==0). EOL = (x==inputXRes).
    - start pulses in the cycle after the SOF pixel is accepted.
    - Accepting pixel (inputXRes, inputYRes) moves the state to DRAIN.
  - DRAIN:
    - srcReady=0.
    - When the FIFO is empty and the output stage is empty, pulse frameDone for one cycle and return to IDLE.
- Output stage:
  - Registered output (dIn, dInValid, dInSof, dInEol).
  - Loads from the FIFO when the stage is empty or when (dInValid && din_Enable).
  - A pixel written at cycle N can appear on dInValid at N+1 at the earliest.
  - dIn is held stable while dInValid=1 and din_Enable=0.
  - Sustained throughput is 1 pixel/clk when srcValid=1 and din_Enable=1.
- FIFO:
  - Pointers are log2(FIFO_DEPTH) bits with an extra wrap bit.
  - Full when the pointers differ only in the wrap bit; empty when equal.
  - Simultaneous push and pop when non-full and non-empty leaves occupancy unchanged.
- Counters:
  - x compares against the latched value only; changes to inputXRes or inputYRes mid-frame have no effect.
  - inputXRes=0 is legal: every pixel has EOL=1.
  - inputXRes=0 and inputYRes=0 together give a single-pixel frame with SOF=EOL=1.

Optional Feature:
CHANNEL_REVERSE_EN
- Defined: channel order of srcData is reversed before the FIFO write, so a BMP BGR word becomes RGB with channel CHANNELS-1 in the LSBs. Applies to every stored pixel.
- Undefined: srcData is stored unchanged.
- Discarded words are unaffected either way.

Decomposition:
- Shared package scaler_pkg:
  - state encoding constants FEED_IDLE, FEED_DISCARD, FEED_ACTIVE, FEED_DRAIN
  - PIX_W = DATA_WIDTH*CHANNELS
  - FIFO word layout constants: SOF bit at PIX_W, EOL bit at PIX_W+1
- One sub-module, scaler_pixel_fifo: synchronous FIFO of width PIX_W+2 and depth FIFO_DEPTH, exporting full, empty, push and pop. The FSM, counters and output register stay in the top.

Test Plan:
1. Basic frame: inputXRes=3, inputYRes=1, discard=2, srcValid always 1, words 0x000001 upward, din_Enable always 1.
   - Words 1 and 2 are dropped; dIn carries 3..10.
   - dInSof with 3; dInEol with 6 and 10.
   - start pulses once; frameDone pulses once after the 10 leaves the output stage.
2. Zero discard: same frame with discard=0.
   - First dIn is 1; DISCARD is never entered (busy rises, start follows the first handshake).
3. Back-pressure: din_Enable=0 for 20 cycles mid-frame, FIFO_DEPTH=8.
   - srcReady drops after 8 buffered pixels plus the one in the output register.
   - dIn holds its value; no pixel is lost or duplicated; order is preserved.
4. Reset mid-frame: assert rst_n=0 while in ACTIVE.
   - All outputs go to 0 asynchronously.
   - A fresh frameGo produces a complete, correctly tagged frame.
5. Ignored arm: a frameGo pulse during ACTIVE causes no relatch, and the frame completes with the original resolution. The same scenario with CHANNEL_REVERSE_EN defined maps srcData 0x112233 to dIn 0x332211.
